wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file.
- Merges two result sources into the file's single write port, one write per cycle:
  - the single-cycle ALU path;
  - the multi-cycle multiply/divide unit.
- Holds a deferred mult/div result in a one-entry buffer and bounds its starvation.
- Keeps a busy scoreboard of registers with outstanding mult/div results, which decode uses for hazard stalls.

---
 rtl/wb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter : writeback arbiter directly upstream of the register file.
//
// The register file has one write port. Two sources compete for it:
//   - the single-cycle ALU path (alu_*), which always wins when it can;
//   - the multi-cycle mult/div unit (md_*). If it loses, its result is parked
//     in a one-entry buffer. The buffer is forced out after it has lost
//     STARVE_LIMIT cycles in a row.
// busy_mask tracks registers with outstanding mult/div results. Decode uses it
// to stall on hazards.
//
// Handshake: a source presents *_valid with rd/data. The result is consumed in
// the same cycle when *_ready=1 (combinational). md_* is held by its producer
// until md_ready. An ALU result with alu_valid=1 and alu_ready=0 is not
// consumed.
//
// Ports:
//   clock, ctrl_reset             : clock (rising edge) and async active-high reset
//   alu_valid/alu_rd/alu_data     : ALU result in,  alu_ready out
//   md_valid/md_rd/md_data        : mult/div result in, md_ready out
//   md_issue_valid/md_issue_rd    : decode issued a mult/div op (sets busy bit)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : registered regfile write
//   busy_mask                     : outstanding mult/div destinations
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              md_valid,
  input  logic [4:0]        md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  input  logic              md_issue_valid,
  input  logic [4:0]        md_issue_rd,
  output logic              ctrl_writeEnable,
  output logic [4:0]        ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic [31:0]       busy_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // buffer empty
    PEND  = 2'd1,  // buffer full
    FORCE = 2'd2   // buffer full and starved long enough: it goes next
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [4:0]        buf_rd_q, buf_rd_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              we_q, we_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              src_md_q, src_md_d;   // registered write came from mult/div
  logic [31:0]       busy_q, busy_d;

  logic              emit;
  logic              emit_md;
  logic [4:0]        emit_rd;
  logic [DATA_W-1:0] emit_data;
  logic [3:0]        starve_inc;

  assign starve_inc = starve_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    alu_ready  = 1'b0;
    md_ready   = (state_q == IDLE);
    emit       = 1'b0;
    emit_md    = 1'b0;
    emit_rd    = '0;
    emit_data  = '0;

    case (state_q)
      FORCE: begin
        emit      = 1'b1;
        emit_md   = 1'b1;
        emit_rd   = buf_rd_q;
        emit_data = buf_data_q;
        state_d   = IDLE;
        starve_d  = '0;
      end
      PEND: begin
        if (!alu_valid) begin
          emit      = 1'b1;
          emit_md   = 1'b1;
          emit_rd   = buf_rd_q;
          emit_data = buf_data_q;
          state_d   = IDLE;
          starve_d  = '0;
        end else begin
          // ALU wins; the buffered result loses one more round.
          alu_ready = 1'b1;
          emit      = 1'b1;
          emit_rd   = alu_rd;
          emit_data = alu_data;
          starve_d  = starve_inc;
          if (starve_inc == LIMIT) state_d = FORCE;
        end
      end
      default: begin  // IDLE
        if (alu_valid) begin
          alu_ready = 1'b1;
          emit      = 1'b1;
          emit_rd   = alu_rd;
          emit_data = alu_data;
          if (md_valid) begin
            // md is accepted anyway (md_ready=1) and parked.
            buf_rd_d   = md_rd;
            buf_data_d = md_data;
            state_d    = PEND;
            starve_d   = '0;
          end
        end else if (md_valid) begin
          emit      = 1'b1;
          emit_md   = 1'b1;
          emit_rd   = md_rd;
          emit_data = md_data;
        end
      end
    endcase

    // Address/data hold when nothing is emitted; r0 writes keep enable low.
    we_d     = emit && (emit_rd != 5'd0);
    wreg_d   = emit ? emit_rd   : wreg_q;
    wdata_d  = emit ? emit_data : wdata_q;
    src_md_d = emit ? emit_md   : src_md_q;

    // Clear first so a same-edge re-issue of the register wins.
    busy_d = busy_q;
    if (we_q && src_md_q) busy_d[wreg_q] = 1'b0;
    if (md_issue_valid && (md_issue_rd != 5'd0)) busy_d[md_issue_rd] = 1'b1;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      we_q       <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      src_md_q   <= 1'b0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      we_q       <= we_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      src_md_q   <= src_md_d;
      busy_q     <= busy_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign busy_mask        = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter : self-checking bench for wb_arbiter.
// A behavioural model (a parked-result slot, a loss count and a busy bit
// array) predicts the outputs each cycle. A negedge process compares the DUT
// against it. Directed sequences also pin literal values.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic ctrl_reset;
  always #5 clock = ~clock;

  logic              alu_valid, alu_ready, md_valid, md_ready, md_issue_valid;
  logic [4:0]        alu_rd, md_rd, md_issue_rd, ctrl_writeReg;
  logic [DATA_W-1:0] alu_data, md_data, data_writeReg;
  logic              ctrl_writeEnable;
  logic [31:0]       busy_mask;

  wb_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .md_issue_valid(md_issue_valid), .md_issue_rd(md_issue_rd),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .busy_mask(busy_mask)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // parked: a mult/div result waiting for the port; losses: rounds it lost.
  logic              m_parked;
  logic [4:0]        m_park_rd;
  logic [DATA_W-1:0] m_park_data;
  int                m_losses;
  logic              m_we, m_src_md;
  logic [4:0]        m_reg;
  logic [DATA_W-1:0] m_data;
  logic              m_busy [32];
  // next-cycle values
  logic              n_parked, n_we, n_src_md;
  logic [4:0]        n_park_rd, n_reg;
  logic [DATA_W-1:0] n_park_data, n_data;
  int                n_losses;
  logic              n_busy [32];
  // combinational expectations for the current cycle
  logic              exp_alu_ready, exp_md_ready;
  logic              last_alu_ready, last_md_ready;
  logic              in_reset = 1'b1;
  logic              run_cmp  = 1'b0;

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_parked = 0; m_park_rd = 0; m_park_data = 0; m_losses = 0;
    m_we = 0; m_reg = 0; m_data = 0; m_src_md = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    exp_alu_ready = 0; exp_md_ready = 1;
  endtask

  task automatic model_eval();
    logic              out;
    logic              out_md;
    logic [4:0]        out_rd;
    logic [DATA_W-1:0] out_data;
    out = 0; out_md = 0; out_rd = 0; out_data = 0;
    n_parked = m_parked; n_park_rd = m_park_rd; n_park_data = m_park_data;
    n_losses = m_losses;
    exp_md_ready  = !m_parked;
    exp_alu_ready = 0;
    if (m_parked && m_losses >= LIMIT) begin
      out = 1; out_md = 1; out_rd = m_park_rd; out_data = m_park_data;
    end else if (m_parked && !alu_valid) begin
      out = 1; out_md = 1; out_rd = m_park_rd; out_data = m_park_data;
    end else if (alu_valid) begin
      exp_alu_ready = 1;
      out = 1; out_rd = alu_rd; out_data = alu_data;
      if (!m_parked && md_valid) begin
        n_parked = 1; n_park_rd = md_rd; n_park_data = md_data; n_losses = 0;
      end
    end else if (!m_parked && md_valid) begin
      out = 1; out_md = 1; out_rd = md_rd; out_data = md_data;
    end
    if (m_parked) begin
      if (out_md) begin n_parked = 0; n_losses = 0; end
      else n_losses = m_losses + 1;
    end
    n_we     = out && (out_rd != 0);
    n_reg    = out ? out_rd   : m_reg;
    n_data   = out ? out_data : m_data;
    n_src_md = out ? out_md   : m_src_md;
    for (int i = 0; i < 32; i++) n_busy[i] = m_busy[i];
    if (m_we && m_src_md) n_busy[m_reg] = 0;
    if (md_issue_valid && md_issue_rd != 0) n_busy[md_issue_rd] = 1;
  endtask

  task automatic model_commit();
    m_parked = n_parked; m_park_rd = n_park_rd; m_park_data = n_park_data;
    m_losses = n_losses;
    m_we = n_we; m_reg = n_reg; m_data = n_data; m_src_md = n_src_md;
    for (int i = 0; i < 32; i++) m_busy[i] = n_busy[i];
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (run_cmp && !in_reset) begin
      chk("alu_ready", alu_ready, exp_alu_ready);
      chk("md_ready", md_ready, exp_md_ready);
      chk("writeEnable", ctrl_writeEnable, m_we);
      chk("writeReg", ctrl_writeReg, m_reg);
      chk("writeData", data_writeReg, m_data);
      chk("busy_mask", busy_mask, model_busy_vec());
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the next one.
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic iv, input logic [4:0] ird);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    md_valid = mv; md_rd = mrd; md_data = md;
    md_issue_valid = iv; md_issue_rd = ird;
    #1;
    model_eval();
    last_alu_ready = alu_ready;
    last_md_ready  = md_ready;
    @(posedge clock); #1;
    model_commit();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // random producer state
  logic              a_hold, m_pend, av_r, iv_r;
  logic [4:0]        ard_r, mrd_r, ird_r;
  logic [DATA_W-1:0] ad_r, md_r;
  logic [31:0]       busy_before;

  initial begin
    ctrl_reset = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
    md_issue_valid = 0; md_issue_rd = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_we", ctrl_writeEnable, 0);
    chk("reset_reg", ctrl_writeReg, 0);
    chk("reset_data", data_writeReg, 0);
    chk("reset_busy", busy_mask, 0);
    chk("reset_md_ready", md_ready, 1);
    ctrl_reset = 1'b0; in_reset = 1'b0; run_cmp = 1'b1;

    // ALU-only stream
    drive(1, 5, 32'h11, 0, 0, 0, 0, 0);
    chk("alu1_md_ready", last_md_ready, 1);
    chk("alu1_we", ctrl_writeEnable, 1);
    chk("alu1_reg", ctrl_writeReg, 5);
    chk("alu1_data", data_writeReg, 32'h11);
    drive(1, 6, 32'h22, 0, 0, 0, 0, 0);
    chk("alu2_md_ready", last_md_ready, 1);
    chk("alu2_reg", ctrl_writeReg, 6);
    chk("alu2_data", data_writeReg, 32'h22);
    idle(1);
    chk("alu_idle_we", ctrl_writeEnable, 0);
    chk("alu_idle_hold", data_writeReg, 32'h22);

    // Collision
    drive(1, 3, 32'hAAAA, 1, 4, 32'hBBBB, 0, 0);
    chk("col_md_ready_t", last_md_ready, 1);
    chk("col_alu_reg", ctrl_writeReg, 3);
    chk("col_alu_data", data_writeReg, 32'hAAAA);
    idle(1);
    chk("col_md_ready_t1", last_md_ready, 0);
    chk("col_md_we", ctrl_writeEnable, 1);
    chk("col_md_reg", ctrl_writeReg, 4);
    chk("col_md_data", data_writeReg, 32'hBBBB);
    idle(1);

    // Starvation: rd=7 parked while ALU keeps requesting
    drive(1, 1, 32'h100, 1, 7, 32'h777, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      drive(1, 5'(k + 10), 32'h200 + k, 0, 0, 0, 0, 0);
      chk("starve_alu_ready", last_alu_ready, (k <= 4) ? 1 : 0);
    end
    chk("starve_we", ctrl_writeEnable, 1);
    chk("starve_reg", ctrl_writeReg, 7);
    chk("starve_data", data_writeReg, 32'h777);
    idle(1);
    chk("starve_back_idle", last_md_ready, 1);

    // Scoreboard
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    chk("sb_set9", busy_mask[9], 1);
    idle(9);
    chk("sb_hold9", busy_mask[9], 1);
    drive(0, 0, 0, 1, 9, 32'h999, 0, 0);
    chk("sb_we9", ctrl_writeEnable, 1);
    chk("sb_still9", busy_mask[9], 1);
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    chk("sb_reissue9", busy_mask[9], 1);
    drive(0, 0, 0, 0, 0, 0, 1, 10);
    drive(0, 0, 0, 1, 10, 32'hA0A0, 0, 0);
    chk("sb_busy10_write", busy_mask[10], 1);
    idle(1);
    chk("sb_clear10", busy_mask[10], 0);
    chk("sb_keep9", busy_mask[9], 1);

    // R0 handling
    busy_before = busy_mask;
    drive(0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
    chk("r0_md_ready", last_md_ready, 1);
    chk("r0_we", ctrl_writeEnable, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("r0_busy_same", busy_mask, busy_before);
    chk("r0_bit0", busy_mask[0], 0);

    // Randomized traffic
    a_hold = 0; m_pend = 0;
    av_r = 0; ard_r = 0; ad_r = 0; mrd_r = 0; md_r = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!a_hold) begin
        av_r  = ($urandom_range(0, 99) < 60);
        ard_r = 5'($urandom_range(0, 31));
        ad_r  = $urandom;
      end
      if (!m_pend && ($urandom_range(0, 99) < 40)) begin
        m_pend = 1;
        mrd_r  = 5'($urandom_range(0, 31));
        md_r   = $urandom;
      end
      iv_r  = ($urandom_range(0, 9) < 3);
      ird_r = 5'($urandom_range(0, 31));
      drive(av_r, ard_r, ad_r, m_pend, mrd_r, md_r, iv_r, ird_r);
      a_hold = av_r && !exp_alu_ready;
      if (m_pend && exp_md_ready) m_pend = 0;
    end
    idle(8);

    // Async reset while a result is parked and busy bits are set
    drive(0, 0, 0, 0, 0, 0, 1, 12);
    drive(1, 2, 32'h1234, 1, 8, 32'h8888, 1, 8);
    drive(1, 3, 32'h5678, 0, 0, 0, 0, 0);
    chk("pre_reset_busy8", busy_mask[8], 1);
    chk("pre_reset_parked", md_ready, 0);
    #2;
    in_reset = 1'b1;
    ctrl_reset = 1'b1;
    #1;
    chk("arst_we", ctrl_writeEnable, 0);
    chk("arst_reg", ctrl_writeReg, 0);
    chk("arst_data", data_writeReg, 0);
    chk("arst_busy", busy_mask, 0);
    model_reset();
    alu_valid = 0; md_valid = 0; md_issue_valid = 0;
    @(posedge clock); #1;
    ctrl_reset = 1'b0; in_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("post_reset_no_write", ctrl_writeEnable, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
